// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect beats sequential step, and redirect
// targets are forced halfword-aligned by clearing bit 0.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_seq,
  input  logic            load_redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] BIT0_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_redirect) begin
      pc_d = redirect_addr & BIT0_MASK;
    end else if (load_seq) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_ADDR & BIT0_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: one outstanding imem request, wrong-path responses are
// dropped after a redirect, fetched words are held for decode in a register.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic            instValid_q, instValid_d;
  logic [ILEN-1:0] instData_q, instData_d;
  logic [XLEN-1:0] instPc_q, instPc_d;
  logic            loadSeq;
  logic [XLEN-1:0] pc;

  fetch_pc_reg #(
    .XLEN      (XLEN),
    .RESET_ADDR(RESET_ADDR)
  ) u_pc (
    .clock        (clock),
    .reset        (reset),
    .load_seq     (loadSeq),
    .load_redirect(redirect),
    .redirect_addr(redirect_addr),
    .pc           (pc)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    instValid_d = instValid_q;
    instData_d  = instData_q;
    instPc_d    = instPc_q;
    loadSeq     = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        if (imem_req_ready) begin
          state_d = FETCH_WAIT;
          drop_d  = redirect;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          // A response racing a redirect belongs to the old path.
          if (drop_q || redirect) begin
            state_d = FETCH_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d     = FETCH_HOLD;
            instValid_d = 1'b1;
            instData_d  = imem_resp_data;
            instPc_d    = pc;
            loadSeq     = 1'b1;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (redirect || inst_ready) begin
          state_d     = FETCH_REQ;
          instValid_d = 1'b0;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH_REQ;
      drop_q      <= 1'b0;
      instValid_q <= 1'b0;
      instData_q  <= '0;
      instPc_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      instValid_q <= instValid_d;
      instData_q  <= instData_d;
      instPc_q    <= instPc_d;
    end
  end

  assign imem_req_valid = (state_q == FETCH_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = instValid_q;
  assign inst_data      = instData_q;
  assign inst_pc        = instPc_q;

  // Memory must only answer while a request is outstanding.
  respOnlyInWait: assert property (@(posedge clock) disable iff (reset)
    imem_resp_valid |-> (state_q == FETCH_WAIT));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, reset corner case, and a
// randomized run checked against a PC-stream reference model.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] raddr;
    logic        irdy;
    logic        expReqV;
    logic [31:0] expAddr;
    logic        expIv;
    logic [31:0] expIpc;
    logic [31:0] expIdata;
  } vec_t;

  vec_t vecs[$];

  fetch_sequencer #(
    .XLEN      (32),
    .RESET_ADDR(32'h100)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic vec_t mkVec(input logic rdy, input logic rv, input logic [31:0] rdata,
                                 input logic redir, input logic [31:0] raddr, input logic irdy,
                                 input logic eReqV, input logic [31:0] eAddr, input logic eIv,
                                 input logic [31:0] eIpc, input logic [31:0] eIdata);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir; v.raddr = raddr; v.irdy = irdy;
    v.expReqV = eReqV; v.expAddr = eAddr; v.expIv = eIv; v.expIpc = eIpc; v.expIdata = eIdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    imem_req_ready  = v.rdy;
    imem_resp_valid = v.rv;
    imem_resp_data  = v.rdata;
    redirect        = v.redir;
    redirect_addr   = v.raddr;
    inst_ready      = v.irdy;
  endtask

  task automatic idleInputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect        = 1'b0;
    redirect_addr   = 32'h0;
    inst_ready      = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd1);
    checkOutput({tag, "_req_addr"}, imem_req_addr, 32'h100);
    checkOutput({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    checkOutput({tag, "_inst_pc"}, inst_pc, 32'h0);
    checkOutput({tag, "_inst_data"}, inst_data, 32'h0);
  endtask

  // Random-phase model state: expected PC of next correct-path instruction
  // plus the environment's memory that answers handshaken requests.
  logic [31:0] expPc;
  logic        memPending;
  int          memCount;
  logic [31:0] memAddr;
  logic        sReqV, sIv;
  logic [31:0] sAddr;
  int          deliveries;
  int          stall;

  initial begin
    idleInputs();
    reset = 1'b1;
    #2;
    checkResetState("reset");
    #10;
    reset = 1'b0;
    #1;
    checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h100);

    // rdy, rv, rdata, redir, raddr, irdy | reqV, addr, iv, ipc, idata
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h100,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA100,0,32'h0,0,     0,32'h104,1,32'h100,32'hA100));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,        1,32'h104,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,1,        0,32'h104,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA104,0,32'h0,1,     0,32'h108,1,32'h104,32'hA104));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,        1,32'h108,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,1,        0,32'h108,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA108,0,32'h0,1,     0,32'h10C,1,32'h108,32'hA108));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,        1,32'h10C,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h10C,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA10C,0,32'h0,0,     0,32'h110,1,32'h10C,32'hA10C));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,      0,32'h110,1,32'h10C,32'hA10C));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,        1,32'h110,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h110,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,1,32'h2000,0,     0,32'h2000,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,0,        0,32'h2000,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA110,0,32'h0,1,     1,32'h2000,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h2000,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA2000,1,32'h3001,1, 1,32'h3000,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h3000,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA3000,0,32'h0,0,    0,32'h3004,1,32'h3000,32'hA3000));
    vecs.push_back(mkVec(0,0,32'h0,1,32'h400,1,      1,32'h400,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,0,32'h0,1,32'hFFFFFFFC,0, 1,32'hFFFFFFFC,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'hFFFFFFFC,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hDEADBEEF,0,32'h0,0, 0,32'h0,1,32'hFFFFFFFC,32'hDEADBEEF));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,1,32'h501,0,      0,32'h500,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'h11111111,0,32'h0,1, 1,32'h500,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h500,0,32'h0,32'h0));
    vecs.push_back(mkVec(0,1,32'hA500,0,32'h0,0,     0,32'h504,1,32'h500,32'hA500));
    vecs.push_back(mkVec(0,0,32'h0,0,32'h0,1,        1,32'h504,0,32'h0,32'h0));
    vecs.push_back(mkVec(1,0,32'h0,0,32'h0,0,        0,32'h504,0,32'h0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].expReqV});
      checkOutput($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].expIv});
      if (vecs[i].expIv) begin
        checkOutput($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].expIpc);
        checkOutput($sformatf("vec%0d_inst_data", i), inst_data, vecs[i].expIdata);
      end
    end

    // Reset asserted mid-WAIT takes effect without a clock edge.
    idleInputs();
    #3;
    reset = 1'b1;
    #1;
    checkResetState("midreset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("postreset_req_addr", imem_req_addr, 32'h100);
    @(posedge clock);
    #1;
    checkOutput("postreset_hold_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("postreset_hold_addr", imem_req_addr, 32'h100);

    // Randomized run against the PC-stream model.
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    expPc      = 32'h100;
    memPending = 1'b0;
    memCount   = 0;
    memAddr    = 32'h0;
    deliveries = 0;
    stall      = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sReqV = imem_req_valid;
      sAddr = imem_req_addr;
      sIv   = inst_valid;
      checkOutput("rand_req_inst_exclusive", {31'b0, sReqV & sIv}, 32'd0);
      if (sReqV) checkOutput("rand_req_addr", sAddr, expPc);
      if (sIv) begin
        checkOutput("rand_inst_pc", inst_pc, expPc);
        checkOutput("rand_inst_data", inst_data, memData(expPc));
      end

      imem_req_ready  = 1'($urandom_range(0, 1));
      imem_resp_valid = memPending && (memCount == 0);
      imem_resp_data  = imem_resp_valid ? memData(memAddr) : $urandom;
      redirect        = ($urandom_range(0, 15) == 0);
      redirect_addr   = $urandom & 32'h000F_FFFF;
      inst_ready      = ($urandom_range(0, 3) != 0);

      @(posedge clock);

      if (redirect) begin
        expPc = redirect_addr & ~32'h1;
      end else if (sIv && inst_ready) begin
        expPc = expPc + 32'd4;
        deliveries++;
        stall = 0;
      end
      stall++;
      if (memPending) begin
        if (memCount == 0) memPending = 1'b0;
        else memCount--;
      end
      if (sReqV && imem_req_ready) begin
        memPending = 1'b1;
        memAddr    = sAddr;
        memCount   = $urandom_range(0, 2);
      end
      if (stall > 400) begin
        checkOutput("rand_stall_bound", stall, 400);
        break;
      end
      #1;
    end
    checkOutput("rand_deliveries_nonzero", {31'b0, deliveries > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
